// File: rtl/srio_dma_comb_arb.sv
// srio_dma_comb_arb: packet-granular round-robin arbiter in front of the SRIO
// DMA combiner. One source is granted per packet and its AXI-Stream beats are
// passed through combinationally (no buffering, no added latency). Accepted
// packets are counted against a software quota; status mirrors the combiner's
// cmd/status register scheme.
//
// Handshake: a beat moves on a rising edge when TVALID and TREADY are both 1 on
// the same interface; in XFER the granted source's TREADY is the combiner's
// TREADY, so both sides of the pass-through handshake on the same edge.
//
// Optional build macro SRIO_DMA_COMB_ARB_SRCID_EN: when defined, M_AXIS_TUSER
// [31:28] carries the grant index so the combiner can tell packet origins apart.
module srio_dma_comb_arb #(
  parameter int NUM_SRC = 2,
  parameter int GW      = 2
) (
  input  logic                  AXIS_ACLK,
  input  logic                  AXIS_ARESET,
  input  logic [NUM_SRC-1:0]    S_AXIS_TVALID,
  output logic [NUM_SRC-1:0]    S_AXIS_TREADY,
  input  logic [64*NUM_SRC-1:0] S_AXIS_TDATA,
  input  logic [NUM_SRC-1:0]    S_AXIS_TLAST,
  input  logic [32*NUM_SRC-1:0] S_AXIS_TUSER,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic [63:0]           M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  output logic [31:0]           M_AXIS_TUSER,
  input  logic [31:0]           cmd,
  input  logic [31:0]           num_pkts,
  output logic [31:0]           status,
  output logic [31:0]           pkt_cnt,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   rr_next;
  logic [31:0]     quota_reg;

  logic            arb_found;
  logic [GW-1:0]   arb_pick;
  logic            sel_valid;
  logic [63:0]     sel_data;
  logic            sel_last;
  logic [31:0]     sel_user;
  logic            last_hs;
  logic            quota_hit;
  logic            unused_ok;

  // Round-robin scan: first valid source at or after rr_ptr, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!arb_found && ((int'(rr_ptr) + k) % NUM_SRC == i) && S_AXIS_TVALID[i]) begin
          arb_found = 1'b1;
          arb_pick  = GW'(i);
        end
      end
    end
  end

  // Select the granted source's stream signals.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_user  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant == GW'(i)) begin
        sel_valid = S_AXIS_TVALID[i];
        sel_data  = S_AXIS_TDATA[64*i +: 64];
        sel_last  = S_AXIS_TLAST[i];
        sel_user  = S_AXIS_TUSER[32*i +: 32];
      end
    end
  end

  assign last_hs   = (state == S_XFER) && sel_valid && M_AXIS_TREADY && sel_last;
  assign quota_hit = (quota_reg != 32'd0) && ((pkt_cnt + 32'd1) == quota_reg);
  assign rr_next   = (grant == GW'(NUM_SRC - 1)) ? '0 : grant + GW'(1);

  // State and datapath registers; hard reset outranks the soft reset bit.
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET || cmd[1]) begin
      state     <= S_IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      pkt_cnt   <= '0;
      quota_reg <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && cmd[0]) begin
        quota_reg <= num_pkts;
      end
      if (state == S_ARB && cmd[0] && arb_found) begin
        grant <= arb_pick;
      end
      if (last_hs) begin
        pkt_cnt <= pkt_cnt + 32'd1;
        rr_ptr  <= rr_next;
      end
    end
  end

  // Next-state: grants only leave ARB; a packet in flight always finishes.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (cmd[0]) state_nxt = S_ARB;
      S_ARB: begin
        if (!cmd[0]) begin
          state_nxt = S_IDLE;
        end else if (arb_found) begin
          state_nxt = S_XFER;
        end
      end
      S_XFER: if (last_hs) state_nxt = quota_hit ? S_DONE : S_ARB;
      S_DONE: state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: pass-through only in XFER, everything quiet elsewhere.
  always_comb begin
    S_AXIS_TREADY = '0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TLAST  = 1'b0;
    M_AXIS_TUSER  = '0;
    if (state == S_XFER) begin
      M_AXIS_TVALID = sel_valid;
      M_AXIS_TDATA  = sel_data;
      M_AXIS_TLAST  = sel_last;
`ifdef SRIO_DMA_COMB_ARB_SRCID_EN
      M_AXIS_TUSER  = {4'(grant), sel_user[27:0]};
`else
      M_AXIS_TUSER  = sel_user;
`endif
      for (int i = 0; i < NUM_SRC; i++) begin
        S_AXIS_TREADY[i] = (grant == GW'(i)) && M_AXIS_TREADY;
      end
    end
  end

  assign status    = {pkt_cnt[15:0], 12'd0, 2'(grant), state == S_XFER, state == S_DONE};
  assign state_dbg = state;
  assign unused_ok = ^{cmd[31:2], sel_user[31:28]};

endmodule

// File: tb/tb_srio_dma_comb_arb.sv
// tb_srio_dma_comb_arb: randomized packet traffic from two sources checked
// against a packet-level round-robin reference model.
module tb_srio_dma_comb_arb;

  localparam int N = 2;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  always #5 clk = ~clk;

  logic [N-1:0]    s_valid;
  logic [N-1:0]    s_ready;
  logic [64*N-1:0] s_data;
  logic [N-1:0]    s_last;
  logic [32*N-1:0] s_user;
  logic            m_valid;
  logic            m_ready;
  logic [63:0]     m_data;
  logic            m_last;
  logic [31:0]     m_user;
  logic [31:0]     cmd;
  logic [31:0]     num_pkts;
  logic [31:0]     status;
  logic [31:0]     pkt_cnt;
  logic [1:0]      unused_state_dbg;

  srio_dma_comb_arb #(.NUM_SRC(N), .GW(2)) dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESET   (rst),
    .S_AXIS_TVALID (s_valid),
    .S_AXIS_TREADY (s_ready),
    .S_AXIS_TDATA  (s_data),
    .S_AXIS_TLAST  (s_last),
    .S_AXIS_TUSER  (s_user),
    .M_AXIS_TVALID (m_valid),
    .M_AXIS_TREADY (m_ready),
    .M_AXIS_TDATA  (m_data),
    .M_AXIS_TLAST  (m_last),
    .M_AXIS_TUSER  (m_user),
    .cmd           (cmd),
    .num_pkts      (num_pkts),
    .status        (status),
    .pkt_cnt       (pkt_cnt),
    .state_dbg     (unused_state_dbg)
  );

  // ---------------- scoreboard / model state ----------------
  // Each entry: {tuser[31:0], tlast, tdata[63:0]}; the source drives its head.
  logic [96:0] src_q [N][$];
  bit          mid_pkt [N];
  bit          gaps, bp;
  bit          in_pkt, en_m, done_m, prev_last;
  int          cur, rr, cnt_m, quota_m, beats;
  int          order_q[$];
  int          comps = 0;
  int          fails = 0;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      mid_pkt[i] = 1'b0;
    end
    in_pkt = 0; en_m = 0; done_m = 0; prev_last = 0;
    cur = 0; rr = 0; cnt_m = 0; quota_m = 0; beats = 0;
    order_q.delete();
  endfunction

  // Which source owns the output right now, or -1 if nobody may move.
  function automatic int owner();
    if (in_pkt) return cur;
    if (!en_m || done_m) return -1;
    for (int k = 0; k < N; k++) begin
      if (src_q[(rr + k) % N].size() != 0) return (rr + k) % N;
    end
    return -1;
  endfunction

  function automatic void add_pkt(int s, int len);
    logic [31:0] u;
    u = $urandom;
    for (int b = 0; b < len; b++) begin
      src_q[s].push_back({u, (b == len - 1), $urandom, $urandom});
    end
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- driver: one clock cycle, starting at a negedge ----------------
  task automatic step();
    int          pred;
    logic [96:0] hd;
    logic [96:0] exp_b;
    logic [96:0] obs_b;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() != 0) begin
        hd = src_q[i][0];
        s_valid[i] = !(gaps && mid_pkt[i] && ($urandom_range(0, 2) == 0));
        s_data[64*i +: 64] = hd[63:0];
        s_last[i] = hd[64];
        s_user[32*i +: 32] = hd[96:65];
      end else begin
        s_valid[i] = 1'b0;
        s_data[64*i +: 64] = {$urandom, $urandom};
        s_last[i] = 1'b0;
        s_user[32*i +: 32] = 32'd0;
      end
    end
    m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    pred = owner();
    for (int i = 0; i < N; i++) begin
      comps++;
      if (s_ready[i] && pred != i) begin
        fails++;
        $display("FAIL tready_owner: src %0d ready=1, expected owner %0d", i, pred);
      end
    end
    if (prev_last) begin
      comps++;
      if (s_ready !== '0) begin
        fails++;
        $display("FAIL arb_gap: ready %b right after a last beat, required 00", s_ready);
      end
    end
    if (status[1]) begin
      comps++;
      if (pred < 0 || int'(status[3:2]) != pred) begin
        fails++;
        $display("FAIL grant: busy with grant %0d, expected owner %0d", status[3:2], pred);
      end
    end
    comps++;
    if (pkt_cnt !== 32'(cnt_m) || status[31:16] !== 16'(cnt_m)) begin
      fails++;
      $display("FAIL pkt_cnt: got %0d (status hi %0d), expected %0d", pkt_cnt, status[31:16], cnt_m);
    end
    comps++;
    if (status[0] !== done_m) begin
      fails++;
      $display("FAIL done_flag: got %b, expected %b", status[0], done_m);
    end
    if (m_valid && m_ready) begin
      beats++;
      comps++;
      if (pred < 0 || src_q[pred].size() == 0) begin
        fails++;
        $display("FAIL spurious_beat: data %h with no owner", m_data);
      end else begin
        hd = src_q[pred].pop_front();
        exp_b = hd;
`ifdef SRIO_DMA_COMB_ARB_SRCID_EN
        exp_b[96:93] = 4'(pred);
`endif
        obs_b = {m_user, m_last, m_data};
        if (obs_b !== exp_b) begin
          fails++;
          $display("FAIL beat: got %h, expected %h (src %0d)", obs_b, exp_b, pred);
        end
        if (!in_pkt) order_q.push_back(int'(status[3:2]));
        mid_pkt[pred] = !hd[64];
        in_pkt = !hd[64];
        cur = pred;
        if (hd[64]) begin
          cnt_m++;
          rr = (pred + 1) % N;
          if (quota_m != 0 && cnt_m == quota_m) done_m = 1'b1;
        end
      end
    end
    prev_last = m_valid && m_ready && m_last;
    @(negedge clk);
  endtask

  task automatic run_until(int budget);
    int cyc;
    cyc = 0;
    while (!(done_m || (all_empty() && !in_pkt)) && cyc < budget) begin
      step();
      cyc++;
    end
    comps++;
    if (cyc >= budget) begin
      fails++;
      $display("FAIL timeout: traffic still pending after %0d cycles", budget);
    end
  endtask

  task automatic set_en(bit en);
    cmd[0] = en;
    en_m = en;
    if (en) quota_m = int'(num_pkts);
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd = 32'd0; num_pkts = 32'd0; m_ready = 1'b0;
    s_valid = '0; s_data = '0; s_last = '0; s_user = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    gaps = 0; bp = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; cmd = 32'h1; num_pkts = $urandom; m_ready = 1'b1;
    s_valid = '1; s_last = '1;
    s_data = {$urandom, $urandom, $urandom, $urandom};
    s_user = {$urandom, $urandom};
    repeat (2) @(negedge clk);
    #1;
    comps++; if (s_ready !== '0) begin fails++; $display("FAIL reset_tready: got %b, expected 0", s_ready); end
    comps++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_mvalid: got %b, expected 0", m_valid); end
    comps++; if (m_data !== 64'd0) begin fails++; $display("FAIL reset_mdata: got %h, expected 0", m_data); end
    comps++; if (m_last !== 1'b0) begin fails++; $display("FAIL reset_mlast: got %b, expected 0", m_last); end
    comps++; if (m_user !== 32'd0) begin fails++; $display("FAIL reset_muser: got %h, expected 0", m_user); end
    comps++; if (status !== 32'd0) begin fails++; $display("FAIL reset_status: got %h, expected 0", status); end
    comps++; if (pkt_cnt !== 32'd0) begin fails++; $display("FAIL reset_pkt_cnt: got %0d, expected 0", pkt_cnt); end
    @(negedge clk);
  endtask

  task automatic test_single_source();
    do_reset();
    num_pkts = 32'd3;
    for (int p = 0; p < 3; p++) add_pkt(0, 4);
    set_en(1);
    run_until(200);
    repeat (5) step();
    comps++; if (beats != 12) begin fails++; $display("FAIL single_beats: got %0d, expected 12", beats); end
    comps++; if (pkt_cnt !== 32'd3) begin fails++; $display("FAIL single_cnt: got %0d, expected 3", pkt_cnt); end
    comps++; if (status !== 32'h0003_0001) begin fails++; $display("FAIL single_status: got %h, expected 00030001", status); end
  endtask

  task automatic test_fairness();
    int exp_order[4] = '{0, 1, 0, 1};
    do_reset();
    num_pkts = 32'd4;
    for (int p = 0; p < 3; p++) begin
      add_pkt(0, $urandom_range(1, 4));
      add_pkt(1, $urandom_range(1, 4));
    end
    set_en(1);
    run_until(300);
    repeat (6) step();
    comps++; if (order_q.size() != 4) begin fails++; $display("FAIL fair_count: got %0d packets, expected 4", order_q.size()); end
    for (int k = 0; k < 4 && k < order_q.size(); k++) begin
      comps++;
      if (order_q[k] != exp_order[k]) begin
        fails++; $display("FAIL fair_order[%0d]: got %0d, expected %0d", k, order_q[k], exp_order[k]);
      end
    end
    comps++; if (status[0] !== 1'b1 || pkt_cnt !== 32'd4) begin fails++; $display("FAIL fair_done: status %h cnt %0d, expected done with 4", status, pkt_cnt); end
  endtask

  task automatic test_backpressure();
    int total;
    do_reset();
    gaps = 1; bp = 1; total = 0;
    for (int p = 0; p < 4; p++) begin
      for (int s = 0; s < N; s++) begin
        int len;
        len = $urandom_range(1, 6);
        total += len;
        add_pkt(s, len);
      end
    end
    set_en(1);
    run_until(1500);
    repeat (3) step();
    comps++; if (beats != total) begin fails++; $display("FAIL bp_beats: got %0d, expected %0d", beats, total); end
    comps++; if (pkt_cnt !== 32'd8) begin fails++; $display("FAIL bp_cnt: got %0d, expected 8", pkt_cnt); end
  endtask

  task automatic test_quota_zero();
    do_reset();
    for (int p = 0; p < 10; p++) add_pkt(1, $urandom_range(1, 3));
    set_en(1);
    run_until(300);
    repeat (3) step();
    comps++; if (pkt_cnt !== 32'd10) begin fails++; $display("FAIL q0_cnt: got %0d, expected 10", pkt_cnt); end
    comps++; if (status[0] !== 1'b0) begin fails++; $display("FAIL q0_done: got %b, expected 0", status[0]); end
  endtask

  task automatic test_soft_reset();
    int b0, guard;
    do_reset();
    add_pkt(0, 1);
    set_en(1);
    run_until(50);
    add_pkt(0, 5);
    b0 = beats; guard = 0;
    while (beats - b0 < 2 && guard < 50) begin step(); guard++; end
    comps++; if (guard >= 50) begin fails++; $display("FAIL sr_timeout: only %0d beats, expected 2", beats - b0); end
    cmd = 32'h3;
    step();
    model_reset();
    cmd = 32'h0;
    #1;
    comps++; if (s_ready !== '0) begin fails++; $display("FAIL sr_tready: got %b, expected 0", s_ready); end
    comps++; if (m_valid !== 1'b0) begin fails++; $display("FAIL sr_mvalid: got %b, expected 0", m_valid); end
    comps++; if (pkt_cnt !== 32'd0) begin fails++; $display("FAIL sr_cnt: got %0d, expected 0", pkt_cnt); end
    comps++; if (status !== 32'd0) begin fails++; $display("FAIL sr_status: got %h, expected 0", status); end
    @(negedge clk);
    add_pkt(0, 2);
    add_pkt(1, 2);
    set_en(1);
    run_until(60);
    comps++; if (order_q.size() < 1 || order_q[0] != 0) begin fails++; $display("FAIL sr_rr_restart: first grant not source 0 (%0d pkts)", order_q.size()); end
  endtask

  task automatic test_enable_drop();
    int guard;
    do_reset();
    add_pkt(0, 3);
    add_pkt(1, 2);
    set_en(1);
    guard = 0;
    while (beats < 1 && guard < 20) begin step(); guard++; end
    set_en(0);
    repeat (15) step();
    comps++; if (pkt_cnt !== 32'd1) begin fails++; $display("FAIL ed_cnt: got %0d, expected 1", pkt_cnt); end
    comps++; if (src_q[1].size() != 2) begin fails++; $display("FAIL ed_no_grant: src1 has %0d beats left, expected 2", src_q[1].size()); end
    comps++; if (s_ready !== '0 || status[1] !== 1'b0) begin fails++; $display("FAIL ed_quiet: ready %b busy %b, expected 0 0", s_ready, status[1]); end
    num_pkts = 32'd2;
    set_en(1);
    run_until(60);
    repeat (3) step();
    comps++; if (pkt_cnt !== 32'd2 || status[0] !== 1'b1) begin fails++; $display("FAIL ed_relatch: cnt %0d done %b, expected 2 1", pkt_cnt, status[0]); end
    comps++; if (status[3:2] !== 2'd1) begin fails++; $display("FAIL ed_grant: got %0d, expected 1", status[3:2]); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; cmd = 32'd0; num_pkts = 32'd0; m_ready = 1'b0;
    s_valid = '0; s_data = '0; s_last = '0; s_user = '0;
    model_reset();
    gaps = 0; bp = 0;
    @(negedge clk);
    test_reset();
    test_single_source();
    test_fairness();
    test_backpressure();
    test_quota_zero();
    test_soft_reset();
    test_enable_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/srio_dma_comb_arb.md
Name: srio_dma_comb_arb

Overview:
Packet-granular round-robin arbiter that shares one SRIO DMA combiner input between NUM_SRC AXI-Stream packet sources, each carrying a 64-bit data path plus a 32-bit TUSER header.
- Sits directly upstream of the combiner.
- Grants one source per packet and passes the granted stream through combinationally.
- Counts accepted packets against a software quota and reports done and busy status through the same cmd/status register scheme as the combiner.

Parameters:
NUM_SRC, 2, number of requesting sources; legal range 2..4.
GW, 2, grant index width; must satisfy 2**GW >= NUM_SRC.

Ports:
AXIS_ACLK  in  1  clock; all logic on the rising edge.
AXIS_ARESET  in  1  synchronous, active-high reset.
S_AXIS_TVALID  in  NUM_SRC  per-source valid.
S_AXIS_TREADY  out  NUM_SRC  per-source ready.
S_AXIS_TDATA  in  64*NUM_SRC  per-source data; source i occupies bits [64i+63:64i].
S_AXIS_TLAST  in  NUM_SRC  per-source end of packet.
S_AXIS_TUSER  in  32*NUM_SRC  per-source header; held stable for the whole packet.
M_AXIS_TVALID  out  1  to combiner.
M_AXIS_TREADY  in  1  from combiner.
M_AXIS_TDATA  out  64  to combiner.
M_AXIS_TLAST  out  1  to combiner.
M_AXIS_TUSER  out  32  to combiner.
cmd  in  32  bit0 = enable, bit1 = soft reset; other bits ignored.
num_pkts  in  32  packet quota; 0 means unlimited.
status  out  32  bit0 = done, bit1 = busy, bits[3:2] = current grant, bits[31:16] = pkt_cnt[15:0].
pkt_cnt  out  32  packets fully transferred since the last reset.

Behaviour:
- Reset: AXIS_ARESET or cmd[1] (sampled each clock edge, AXIS_ARESET takes priority) forces the following.
  - state = IDLE, grant = 0, rr_ptr = 0, pkt_cnt = 0, quota_reg = 0.
  - All outputs are 0.
- States:
  - IDLE: all TREADY = 0, M_AXIS_TVALID = 0. When cmd[0] = 1, latch num_pkts into quota_reg and go to ARB.
  - ARB: one cycle per evaluation; no handshake is possible in this state.
    - Scan sources starting at rr_ptr, increasing and wrapping; the first with S_AXIS_TVALID = 1 wins. Register it in grant and go to XFER.
    - If no source is valid, stay in ARB.
    - If cmd[0] = 0, return to IDLE.
  - XFER:
    - M_AXIS_TVALID = S_AXIS_TVALID[grant]; TDATA, TLAST and TUSER are muxed from the granted source.
    - S_AXIS_TREADY[grant] = M_AXIS_TREADY; all other TREADY bits are 0.
    - Zero added latency and no buffering.
    - On the last-beat handshake: pkt_cnt increments, rr_ptr = (grant+1) mod NUM_SRC, then go to DONE if quota_reg != 0 and pkt_cnt+1 == quota_reg, otherwise go to ARB.
  - DONE: all TREADY = 0, status[0] = 1. Hold until reset or soft reset.
- Grant timing: grant changes only on leaving ARB, never mid-packet. A source that deasserts valid mid-packet keeps the grant.
- cmd[0] dropped mid-packet: the current packet completes, then the block goes to ARB, which returns to IDLE.
- cmd[0] reasserted: quota_reg relatches; pkt_cnt is not cleared.
- Soft reset mid-packet: the partial packet is abandoned immediately. Software must also reset the combiner.
- Simultaneous last beat and quota reached: DONE takes precedence over ARB.
- pkt_cnt wraps modulo 2**32. With quota 0, DONE is never reached.
- status[1] = 1 only in XFER.
- status[3:2] reflects the grant register, zero-extended.
- rr_ptr wraps from NUM_SRC-1 to 0.
- Out-of-range or unused grant values are unreachable; no error handling is required.

Optional Feature:
SRIO_DMA_COMB_ARB_SRCID_EN
- Defined: M_AXIS_TUSER[31:28] is replaced by the grant index, zero-extended to 4 bits; TUSER[27:0] passes through. Downstream can identify the origin of each combined packet.
- Undefined: M_AXIS_TUSER equals the granted source's TUSER unmodified.

Test Plan:
- Single source: NUM_SRC=2, num_pkts=3, source 0 sends three 4-beat packets, TREADY tied 1 -> 12 output beats, pkt_cnt=3, status = 0x0003_0001.
- Fairness: both sources continuously valid, num_pkts=4 -> grant order 0,1,0,1; no interleaving of beats within a packet.
- Backpressure: M_AXIS_TREADY toggled randomly -> the output stream equals the input stream of the granted source, and the non-granted TREADY is 0 throughout.
- Quota 0: 10 packets from source 1 -> pkt_cnt=10, status[0] stays 0, ARB is re-entered after each packet.
- Soft reset mid-packet: cmd[1] asserted at beat 2 of 5 -> next cycle state IDLE, all TREADY 0, pkt_cnt=0.
- Enable drop: cmd[0] cleared at beat 1 of a 3-beat packet -> the packet completes, pkt_cnt increments, no new grant is issued.
